// File: rtl/snd_arb_rr.sv
// Round-robin send arbiter: merges length-prefixed blocks from NCH channel
// FIFOs onto one DW-bit link word stream with a K-character flag. Trigger
// K-words may preempt a block for one slot without losing the grant.
module snd_arb_rr #(
    parameter int            NCH    = 17,
    parameter int            DW     = 16,
    parameter int            LENW   = 9,
    parameter logic [DW-1:0] IDLE_K = 16'h00BC,
    parameter logic [DW-1:0] TRIG_K = 16'h001C,
    parameter int            TOUT   = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    fifo_req,
    output logic [NCH-1:0]    arb_want,
    input  logic [NCH-1:0]    fifo_have,
    input  logic [NCH*DW-1:0] datain,
    input  logic              trig,
    output logic [DW-1:0]     dataout,
    output logic              kchar,
    output logic              err,
    output logic              trig_ovf
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TW = $clog2(TOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_XFER} state_t;

    state_t          state, state_n;
    logic [PW-1:0]   ptr, ptr_n;
    logic [PW-1:0]   own, own_n;
    logic [LENW-1:0] cnt, cnt_n;
    logic [TW-1:0]   tcnt, tcnt_n;
    logic            pend, pend_n;
    logic [NCH-1:0]  arb_want_n;
    logic [DW-1:0]   dataout_n;
    logic            kchar_n, err_n, ovf_n;

    logic            found;
    logic [PW-1:0]   pick;
    logic            acc;
    logic [DW-1:0]   word;

    // Channel index offset from the round-robin base, wrapped at NCH.
    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NCH) s = s - NCH;
        return PW'(s);
    endfunction

    function automatic logic [NCH-1:0] onehot(input logic [PW-1:0] i);
        return NCH'(1) << i;
    endfunction

    // Round-robin search: first requesting channel at or above the pointer.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int j = 0; j < NCH; j++) begin
            if (!found && fifo_req[wrap_idx(ptr, j)]) begin
                found = 1'b1;
                pick  = wrap_idx(ptr, j);
            end
        end
    end

    // Word from the owned channel and whether it is accepted this cycle.
    always_comb begin
        word = '0;
        for (int i = 0; i < NCH; i++) begin
            if (own == PW'(i)) word = datain[i*DW +: DW];
        end
        acc = |(arb_want & fifo_have);
    end

    // Next-state: block framing, timeout, trigger preemption and output word.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        own_n   = own;
        cnt_n   = cnt;
        tcnt_n  = tcnt;
        err_n   = 1'b0;

        case (state)
            S_IDLE: begin
                if (found) begin
                    own_n   = pick;
                    ptr_n   = (pick == PW'(NCH - 1)) ? '0 : pick + 1'b1;
                    tcnt_n  = '0;
                    state_n = S_HDR;
                end
            end
            S_HDR, S_XFER: begin
                if (acc) begin
                    tcnt_n = '0;
                    if (state == S_HDR) begin
                        if (word[DW-1]) begin
                            cnt_n   = word[LENW-1:0];
                            state_n = (word[LENW-1:0] == '0) ? S_IDLE : S_XFER;
                        end else begin
                            // Malformed header: still forwarded, block abandoned.
                            err_n   = 1'b1;
                            state_n = S_IDLE;
                        end
                    end else if (cnt == LENW'(1)) begin
                        state_n = S_IDLE;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end else if (|arb_want) begin
                    // Only genuinely granted cycles count; trigger slots have arb_want=0.
                    if (tcnt == TW'(TOUT - 1)) begin
                        err_n   = 1'b1;
                        tcnt_n  = '0;
                        state_n = S_IDLE;
                    end else begin
                        tcnt_n = tcnt + 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        // A second trigger while one is pending merges into it.
        pend_n = trig & ~pend;
        ovf_n  = trig & pend;

        // Grant is suspended for the trigger slot but the owner is kept.
        arb_want_n = (state_n != S_IDLE && !pend_n) ? onehot(own_n) : '0;

        if (pend) begin
            dataout_n = TRIG_K;
            kchar_n   = 1'b1;
        end else if (acc) begin
            dataout_n = word;
            kchar_n   = 1'b0;
        end else begin
            dataout_n = IDLE_K;
            kchar_n   = 1'b1;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            ptr      <= '0;
            own      <= '0;
            tcnt     <= '0;
            pend     <= 1'b0;
            arb_want <= '0;
            dataout  <= IDLE_K;
            kchar    <= 1'b1;
            err      <= 1'b0;
            trig_ovf <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            own      <= own_n;
            tcnt     <= tcnt_n;
            pend     <= pend_n;
            arb_want <= arb_want_n;
            dataout  <= dataout_n;
            kchar    <= kchar_n;
            err      <= err_n;
            trig_ovf <= ovf_n;
        end
    end

    // Remaining block length; only meaningful after a valid header.
    always_ff @(posedge clk) begin
        cnt <= cnt_n;
    end

endmodule

// File: doc/snd_arb_rr.md
Name: snd_arb_rr

Overview:
- Parametrised round-robin send arbiter that merges block-structured data from NCH channel FIFOs onto one DW-bit serial-link word stream with a K-character flag.
- Sits between the per-channel block FIFOs and the link transmitter.
- Adds over the previous arbiter:
  - an explicit per-channel block-ready request,
  - fair round-robin grant,
  - header validation,
  - starvation timeout,
  - trigger K-word insertion that can preempt a block mid-transfer.

Parameters:
- NCH, 17, number of channels.
- DW, 16, data word width; bit DW-1 of a data word is the header flag.
- LENW, 9, width of the length field in header bits [LENW-1:0]; LENW <= DW-1.
- IDLE_K, 16'h00BC, idle word emitted with kchar=1.
- TRIG_K, 16'h001C, trigger word emitted with kchar=1.
- TOUT, 255, maximum consecutive granted cycles with fifo_have low before abort.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- fifo_req  in  NCH  channel i holds at least one complete block.
- arb_want  out  NCH  one-hot grant / read enable to channel i.
- fifo_have  in  NCH  channel i word on datain is valid this cycle.
- datain  in  NCH*DW  channel i word at datain[DW*i +: DW].
- trig  in  1  one-cycle trigger pulse.
- dataout  out  DW  link word.
- kchar  out  1  dataout is a K-character.
- err  out  1  one-cycle pulse: bad header or timeout abort.
- trig_ovf  out  1  one-cycle pulse: trig arrived while a trigger word was already pending.

Behaviour:
- Reset state: arb_want=0, dataout=IDLE_K, kchar=1, err=0, trig_ovf=0, round-robin pointer=0, trigger pending=0, state IDLE. Reset mid-transfer drops the grant on the next edge; the partial block is not resumed.
- All outputs are registered.
- Word acceptance: a word is accepted in cycle t when (arb_want[i] & fifo_have[i]). The channel pops that word at the same edge. The accepted word appears on dataout with kchar=0 at t+1.
- Any cycle with no accepted word and no trigger emission outputs IDLE_K, kchar=1.
- Trigger handling:
  - trig sets pending.
  - While pending, the arbiter forces arb_want=0 for one cycle. The next dataout is TRIG_K, kchar=1, and pending clears.
  - Triggers have priority over data in every state. The grant and word counter are held, not lost; arb_want returns to the same channel the cycle after.
  - trig while pending already set: pending stays 1 (merged) and trig_ovf pulses.
- IDLE:
  - Search fifo_req from pointer upward, wrapping at NCH-1 to 0. The first set bit k wins.
  - Next cycle: arb_want=onehot(k), pointer=(k+1) mod NCH, state HDR.
  - No request: stay in IDLE.
- HDR:
  - Accepted word with bit DW-1=1: cnt=word[LENW-1:0].
    - cnt=0: block is header only; go to IDLE and deassert arb_want next cycle.
    - Otherwise go to XFER.
  - Accepted word with bit DW-1=0: word is still forwarded, err pulses, the grant is released, state IDLE.
- XFER:
  - Each accepted word decrements cnt.
  - The word accepted with cnt=1 is the last; arb_want=0 next cycle, state IDLE.
  - A header-flagged word inside a block is forwarded as data, with no check.
- Minimum gap between consecutive blocks is one IDLE_K word: IDLE evaluates in the cycle after the grant drops.
- Timeout: in HDR/XFER a counter (width clog2(TOUT+1)) increments on each granted cycle without fifo_have and clears on acceptance. On reaching TOUT: err pulses, grant is released, state IDLE, no filler is inserted. Trigger-forced cycles do not count.
- fifo_have on non-granted channels is ignored.
- fifo_req of the granted channel is ignored until IDLE.

Test Plan:
- Single block: fifo_req[0]=1; ch0 supplies header 16'h8004 then 4 words with fifo_have=1 → dataout after IDLE_K words: 8004, d1..d4 kchar=0, then IDLE_K. arb_want=17'h00001 asserted for exactly 5 cycles.
- Fairness: fifo_req=17'h00101, each channel sends a blen=4 block repeatedly → grants alternate ch0, ch8, ch0, ch8. Exactly one IDLE_K between blocks. No channel is granted twice in succession.
- Trigger preemption: trig pulse during the 3rd data word of a ch8 block → TRIG_K/kchar=1 inserted at the next output slot. arb_want low that cycle. Block resumes, with all 5 words delivered in order.
- Trigger overflow: trig on two consecutive cycles while ch0 is busy → one TRIG_K only. trig_ovf pulses once.
- Bad header / timeout: ch1 header 16'h0004 → word forwarded, err pulse, grant released. Then ch2 header 8003 followed by fifo_have=0 for TOUT=255 cycles → err pulse, arb_want=0, state IDLE.
- Reset mid-block: assert reset during XFER → next edge: arb_want=0, dataout=IDLE_K, kchar=1. Next grant starts from channel 0.
